// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// The PARITY_EN macro adds the parity state to the state type.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef PARITY_EN
    StParity,
`endif
    StStop
  } uart_state_e;

  localparam logic IdleLevel = 1'b1;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..ClksPerBit-1 and flags the last cycle of each period.
module uart_baud_counter #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == LastCnt);

  // Wrapping at bit_end restarts the count on every bit or state change.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional even parity, one stop bit.
// Define PARITY_EN to insert the even-parity bit (8E1 instead of 8N1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 uart_tx_en,
  output logic                 uart_txd,
  output logic                 uart_tx_busy,
  output logic                 uart_tx_done
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned IdxW       = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end;
`ifdef PARITY_EN
  logic                 parity_q;
`endif

  // Counter is held at zero while idle so START gets a full bit period.
  uart_baud_counter #(
    .ClksPerBit(ClksPerBit)
  ) u_baud (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clr_i    (state_q == StIdle),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= IdleLevel;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (uart_tx_en) begin
            state_q   <= StStart;
            shift_q   <= tx_data;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
`ifdef PARITY_EN
            parity_q  <= ^tx_data;
`endif
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_idx_q == LastIdx) begin
`ifdef PARITY_EN
              state_q <= StParity;
              txd_q   <= parity_q;
`else
              state_q <= StStop;
              txd_q   <= IdleLevel;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
`ifdef PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            txd_q   <= IdleLevel;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          txd_q   <= IdleLevel;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;

endmodule
